// File: rtl/pwmdac_pkg.sv
// Shared definitions for the PWMDAC sample path: sample width and feeder FSM encoding.
// Also used by the PWMDAC core and its bench.
package pwmdac_pkg;

    localparam int SAMPLE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pwmdac_feeder_sample_fifo.sv
// DEPTH x SAMPLE_W register-array FIFO with combinational head word and registered occupancy.
// The caller guarantees no write when full and no read when empty.
module sample_fifo
    import pwmdac_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                wr_en,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic                rd_en,
    output logic [SAMPLE_W-1:0] rd_data,
    output logic [AW:0]         level
);

    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [AW-1:0]       wptr;
    logic [AW-1:0]       rptr;

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en && !rst && !flush) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_en) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_comb begin
        rd_data = mem[rptr];
    end

endmodule

// File: rtl/pwmdac_feeder.sv
// Sample-stream controller feeding the PWMDAC: buffers synth samples, primes before playing,
// recovers from underrun with silence, and flushes on disable.
module pwmdac_feeder
    import pwmdac_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int AW        = 3,
    parameter int PRIME_LVL = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] src_data,
    input  logic                src_valid,
    output logic                src_ready,
    output logic [SAMPLE_W-1:0] dac_din,
    input  logic                dac_ack,
    output logic [AW:0]         level,
    output logic                running,
    output logic [7:0]          underrun_cnt
);

    state_t              state;
    state_t              state_nx;
    logic [AW:0]         fifo_level;
    logic [SAMPLE_W-1:0] head;
    logic                wr_en;
    logic                pop;
    logic                underrun;

    sample_fifo #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .flush  (!enable),
        .wr_en  (wr_en),
        .wr_data(src_data),
        .rd_en  (pop),
        .rd_data(head),
        .level  (fifo_level)
    );

    assign level   = fifo_level;
    assign running = (state == RUN);

    // Disable outranks any same-cycle write or pop, so both are gated by enable here.
    always_comb begin
        src_ready = (state != IDLE) && (fifo_level != (AW+1)'(DEPTH));
        wr_en     = enable && src_valid && src_ready;
        pop       = enable && (state == RUN) && dac_ack && (fifo_level != '0);
        underrun  = enable && (state == RUN) && dac_ack && (fifo_level == '0);
    end

    always_comb begin
        state_nx = state;
        if (!enable) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    state_nx = PRIME;
                PRIME:   if (fifo_level >= (AW+1)'(PRIME_LVL)) state_nx = RUN;
                RUN:     if (underrun) state_nx = PRIME;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Outside a real pop, every ack presents silence.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            dac_din <= '0;
        end else if (dac_ack) begin
            dac_din <= pop ? head : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_cnt <= '0;
        end else if (underrun) begin
            underrun_cnt <= sat_inc8(underrun_cnt);
        end
    end

endmodule

// File: tb/tb_pwmdac_feeder.sv
// Self-checking bench for pwmdac_feeder: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_pwmdac_feeder;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] src_data;
    logic       src_valid;
    logic       src_ready;
    logic [7:0] dac_din;
    logic       dac_ack;
    logic [3:0] level;
    logic       running;
    logic [7:0] underrun_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pwmdac_feeder #(
        .DEPTH    (8),
        .AW       (3),
        .PRIME_LVL(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .dac_din     (dac_din),
        .dac_ack     (dac_ack),
        .level       (level),
        .running     (running),
        .underrun_cnt(underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a sample queue plus "accepting" and "playing" flags.
    logic [7:0] q[$];
    bit         m_on;
    bit         m_play;
    logic [7:0] m_din;
    logic [7:0] m_cnt;

    function automatic void model_step(input bit r, input bit en, input bit v,
                                       input logic [7:0] d, input bit a);
        bit accept;
        if (r) begin
            q.delete();
            m_on = 0; m_play = 0; m_din = 8'h00; m_cnt = 8'h00;
        end else if (!en) begin
            q.delete();
            m_on = 0; m_play = 0; m_din = 8'h00;
        end else begin
            accept = m_on && v && (q.size() < 8);
            if (!m_on) begin
                m_on = 1;
            end else if (!m_play) begin
                if (a) m_din = 8'h00;
                if (q.size() >= 4) m_play = 1;
            end else if (a) begin
                if (q.size() > 0) begin
                    m_din = q.pop_front();
                end else begin
                    m_din  = 8'h00;
                    m_play = 0;
                    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
                end
            end
            if (accept) q.push_back(d);
        end
    endfunction

    task automatic tick(input bit r, input bit en, input bit v, input logic [7:0] d, input bit a);
        rst = r; enable = en; src_valid = v; src_data = d; dac_ack = a;
        @(posedge clk);
        model_step(r, en, v, d, a);
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 1, 8'h55, 1);
        tick(1, 0, 0, 8'h00, 1);
        tick(0, 0, 1, 8'h33, 1);
        n_checks += 5;
        if (dac_din !== 8'h00)      begin n_fail++; $display("FAIL reset_din got=%h exp=00", dac_din); end
        if (level !== 4'd0)         begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
        if (src_ready !== 1'b0)     begin n_fail++; $display("FAIL reset_ready got=%b exp=0", src_ready); end
        if (running !== 1'b0)       begin n_fail++; $display("FAIL reset_running got=%b exp=0", running); end
        if (underrun_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", underrun_cnt); end
    endtask

    task automatic test_prime_play();
        logic [7:0] smp [4];
        smp[0] = 8'h0A; smp[1] = 8'hEC; smp[2] = 8'h1E; smp[3] = 8'hD8;
        tick(0, 1, 0, 8'h00, 0);
        n_checks++;
        if (src_ready !== 1'b1) begin n_fail++; $display("FAIL prime_ready got=%b exp=1", src_ready); end
        for (int i = 0; i < 4; i++) tick(0, 1, 1, smp[i], 0);
        n_checks += 2;
        if (level !== 4'd4)     begin n_fail++; $display("FAIL prime_level got=%0d exp=4", level); end
        if (running !== 1'b0)   begin n_fail++; $display("FAIL prime_early_run got=%b exp=0", running); end
        tick(0, 1, 0, 8'h00, 0);
        n_checks++;
        if (running !== 1'b1)   begin n_fail++; $display("FAIL play_running got=%b exp=1", running); end
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, 0, 8'h00, 1);
            n_checks++;
            if (dac_din !== smp[i]) begin n_fail++; $display("FAIL play_din%0d got=%h exp=%h", i, dac_din, smp[i]); end
            tick(0, 1, 0, 8'h00, 0);
            n_checks++;
            if (dac_din !== smp[i]) begin n_fail++; $display("FAIL hold_din%0d got=%h exp=%h", i, dac_din, smp[i]); end
        end
        n_checks++;
        if (level !== 4'd0) begin n_fail++; $display("FAIL drain_level got=%0d exp=0", level); end
    endtask

    task automatic test_underrun();
        tick(0, 1, 0, 8'h00, 1);
        n_checks += 3;
        if (dac_din !== 8'h00)      begin n_fail++; $display("FAIL ur_din got=%h exp=00", dac_din); end
        if (underrun_cnt !== 8'd1)  begin n_fail++; $display("FAIL ur_cnt got=%0d exp=1", underrun_cnt); end
        if (running !== 1'b0)       begin n_fail++; $display("FAIL ur_running got=%b exp=0", running); end
        for (int i = 0; i < 4; i++) tick(0, 1, 1, 8'(8'h40 + i), 0);
        tick(0, 1, 0, 8'h00, 0);
        n_checks++;
        if (running !== 1'b1) begin n_fail++; $display("FAIL ur_resume got=%b exp=1", running); end
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 4; i++) tick(0, 1, 1, 8'(8'h50 + i), 0);
        tick(0, 1, 1, 8'h77, 0);
        n_checks += 2;
        if (level !== 4'd8)     begin n_fail++; $display("FAIL full_level got=%0d exp=8", level); end
        if (src_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b exp=0", src_ready); end
        tick(0, 1, 1, 8'h78, 1);
        n_checks += 3;
        if (level !== 4'd7)     begin n_fail++; $display("FAIL pop_full_level got=%0d exp=7", level); end
        if (src_ready !== 1'b1) begin n_fail++; $display("FAIL pop_full_ready got=%b exp=1", src_ready); end
        if (dac_din !== 8'h40)  begin n_fail++; $display("FAIL pop_full_din got=%h exp=40", dac_din); end
        tick(0, 1, 1, 8'h79, 1);
        n_checks += 2;
        if (level !== 4'd7)     begin n_fail++; $display("FAIL simul_level got=%0d exp=7", level); end
        if (dac_din !== 8'h41)  begin n_fail++; $display("FAIL simul_din got=%h exp=41", dac_din); end
    endtask

    task automatic test_disable();
        tick(0, 1, 0, 8'h00, 1);
        tick(0, 1, 0, 8'h00, 1);
        n_checks++;
        if (level !== 4'd5) begin n_fail++; $display("FAIL predis_level got=%0d exp=5", level); end
        tick(0, 0, 1, 8'h99, 1);
        n_checks += 5;
        if (running !== 1'b0)      begin n_fail++; $display("FAIL dis_running got=%b exp=0", running); end
        if (level !== 4'd0)        begin n_fail++; $display("FAIL dis_level got=%0d exp=0", level); end
        if (dac_din !== 8'h00)     begin n_fail++; $display("FAIL dis_din got=%h exp=00", dac_din); end
        if (underrun_cnt !== 8'd1) begin n_fail++; $display("FAIL dis_cnt got=%0d exp=1", underrun_cnt); end
        if (src_ready !== 1'b0)    begin n_fail++; $display("FAIL dis_ready got=%b exp=0", src_ready); end
        tick(0, 1, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) tick(0, 1, 1, 8'(8'h60 + i), 0);
        tick(0, 1, 0, 8'h00, 0);
        n_checks++;
        if (running !== 1'b0) begin n_fail++; $display("FAIL reprime_early got=%b exp=0", running); end
        tick(0, 1, 1, 8'h63, 0);
        tick(0, 1, 0, 8'h00, 0);
        n_checks++;
        if (running !== 1'b1) begin n_fail++; $display("FAIL reprime_run got=%b exp=1", running); end
    endtask

    task automatic test_random();
        bit en, v, a;
        for (int c = 0; c < 2000; c++) begin
            en = ($urandom_range(0, 29) != 0);
            v  = ($urandom_range(0, 2) != 0);
            a  = ($urandom_range(0, 2) == 0);
            tick(0, en, v, 8'($urandom), a);
            n_checks += 5;
            if (dac_din !== m_din)   begin n_fail++; $display("FAIL rnd_din c=%0d got=%h exp=%h", c, dac_din, m_din); end
            if (level !== 4'(q.size())) begin n_fail++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, level, q.size()); end
            if (running !== m_play)  begin n_fail++; $display("FAIL rnd_running c=%0d got=%b exp=%b", c, running, m_play); end
            if (src_ready !== (m_on && q.size() != 8)) begin
                n_fail++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, src_ready, m_on && q.size() != 8);
            end
            if (underrun_cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, underrun_cnt, m_cnt); end
        end
    endtask

    task automatic test_saturation_reset();
        int k;
        tick(0, 0, 0, 8'h00, 0);
        for (int u = 0; u < 260; u++) begin
            for (k = 0; k < 40 && !m_play; k++) tick(0, 1, 1, 8'($urandom), 0);
            for (k = 0; k < 40 && m_play; k++) tick(0, 1, 0, 8'h00, 1);
            if (k == 40) begin
                n_checks++; n_fail++;
                $display("FAIL sat_bound u=%0d got=timeout exp=underrun", u);
                break;
            end
        end
        n_checks++;
        if (underrun_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_cnt got=%0d exp=255", underrun_cnt); end
        for (k = 0; k < 40 && !m_play; k++) tick(0, 1, 1, 8'($urandom), 0);
        tick(0, 1, 1, 8'h5A, 1);
        n_checks++;
        if (running !== 1'b1) begin n_fail++; $display("FAIL prerst_running got=%b exp=1", running); end
        tick(1, 1, 1, 8'h5B, 1);
        n_checks += 5;
        if (dac_din !== 8'h00)      begin n_fail++; $display("FAIL rst_din got=%h exp=00", dac_din); end
        if (level !== 4'd0)         begin n_fail++; $display("FAIL rst_level got=%0d exp=0", level); end
        if (src_ready !== 1'b0)     begin n_fail++; $display("FAIL rst_ready got=%b exp=0", src_ready); end
        if (running !== 1'b0)       begin n_fail++; $display("FAIL rst_running got=%b exp=0", running); end
        if (underrun_cnt !== 8'h00) begin n_fail++; $display("FAIL rst_cnt got=%0d exp=0", underrun_cnt); end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; src_valid = 1'b0; src_data = 8'h00; dac_ack = 1'b0;
        m_on = 0; m_play = 0; m_din = 8'h00; m_cnt = 8'h00;
        @(posedge clk);
        #1;
        test_reset();
        test_prime_play();
        test_underrun();
        test_full_simul();
        test_disable();
        tick(0, 1, 0, 8'h00, 0);
        test_random();
        test_saturation_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
